// File: rtl/sysram_port_arb.sv
// Shares one RAM port between PCIe writes, UART writes and a C2H burst reader; `SYSRAM_ARB_RR_EN selects round-robin, else fixed P2>P0>P1.
// Grant->RAM strobe 1 cycle, grant->O_rd_vld RAM_LAT+2 cycles; writers stall via rdy, bursts pause on I_rd_ready, readback never stalls.
module sysram_port_arb #(
  parameter int ADDR_W  = 16,
  parameter int RAM_LAT = 2
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_pxie_wr_vld,
  output logic              O_pxie_wr_rdy,
  input  logic [ADDR_W-1:0] I_pxie_wr_addr,
  input  logic [31:0]       I_pxie_wr_data,
  input  logic              I_uart_wr_vld,
  output logic              O_uart_wr_rdy,
  input  logic [ADDR_W-1:0] I_uart_wr_addr,
  input  logic [31:0]       I_uart_wr_data,
  input  logic              I_rd_start,
  input  logic [ADDR_W-1:0] I_rd_addr,
  input  logic [15:0]       I_rd_len,
  input  logic              I_rd_ready,
  output logic              O_rd_busy,
  output logic              O_rd_vld,
  output logic [31:0]       O_rd_data,
  output logic              O_rd_last,
  output logic              O_rd_done,
  output logic              O_ram_en,
  output logic              O_ram_we,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [31:0]       O_ram_wdata,
  input  logic [31:0]       I_ram_rdata
);

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN} rd_state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  rd_state_e         state_q, state_d;
  logic [15:0]       remain_q, remain_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic              done_q, done_d;

  logic              rd_req;
  logic [2:0]        req, gnt;

  logic              ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic              issue_vld_q, issue_last_q;
  logic [RAM_LAT-1:0] pipe_vld_q, pipe_last_q;
  logic              rd_vld_q, rd_last_q;
  logic [31:0]       rd_data_q;

  assign rd_req = (state_q == RD_RUN) && (remain_q != 16'd0) && I_rd_ready;
  assign req    = {rd_req, I_uart_wr_vld, I_pxie_wr_vld} & {3{~I_rst}};

`ifdef SYSRAM_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    gnt   = 3'b000;
    ptr_d = ptr_q;
    case (ptr_q)
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
    // Pointer moves to the requester after the one just served.
    if (gnt[0])      ptr_d = 2'd1;
    else if (gnt[1]) ptr_d = 2'd2;
    else if (gnt[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt = 3'b000;
    if (req[2])      gnt = 3'b100;
    else if (req[0]) gnt = 3'b001;
    else if (req[1]) gnt = 3'b010;
  end
`endif

  assign O_pxie_wr_rdy = gnt[0];
  assign O_uart_wr_rdy = gnt[1];

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    beat_addr_d = beat_addr_q;
    done_d      = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (I_rd_start) begin
          if (I_rd_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RD_RUN;
            remain_d    = I_rd_len;
            beat_addr_d = I_rd_addr;
          end
        end
      end
      RD_RUN: begin
        if (gnt[2]) begin
          remain_d    = remain_q - 16'd1;
          beat_addr_d = beat_addr_q + ADDR_ONE;
          if (remain_q == 16'd1) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (rd_vld_q && rd_last_q) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= RD_IDLE;
      remain_q    <= 16'd0;
      beat_addr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      beat_addr_q <= beat_addr_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 32'd0;
      issue_vld_q  <= 1'b0;
      issue_last_q <= 1'b0;
    end else begin
      ram_en_q     <= |gnt;
      ram_we_q     <= gnt[0] | gnt[1];
      issue_vld_q  <= gnt[2];
      issue_last_q <= gnt[2] && (remain_q == 16'd1);
      if (gnt[0]) begin
        ram_addr_q  <= I_pxie_wr_addr;
        ram_wdata_q <= I_pxie_wr_data;
      end else if (gnt[1]) begin
        ram_addr_q  <= I_uart_wr_addr;
        ram_wdata_q <= I_uart_wr_data;
      end else if (gnt[2]) begin
        ram_addr_q  <= beat_addr_q;
        ram_wdata_q <= 32'd0;
      end
    end
  end

  // Delay line matching the RAM latency; the tail stage marks the cycle I_ram_rdata is valid.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= 32'd0;
    end else begin
      pipe_vld_q[0]  <= issue_vld_q;
      pipe_last_q[0] <= issue_last_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
      rd_vld_q  <= pipe_vld_q[RAM_LAT-1];
      rd_last_q <= pipe_vld_q[RAM_LAT-1] & pipe_last_q[RAM_LAT-1];
      if (pipe_vld_q[RAM_LAT-1]) rd_data_q <= I_ram_rdata;
    end
  end

  assign O_rd_busy   = (state_q != RD_IDLE);
  assign O_rd_vld    = rd_vld_q;
  assign O_rd_data   = rd_data_q;
  assign O_rd_last   = rd_last_q;
  assign O_rd_done   = done_q;
  assign O_ram_en    = ram_en_q;
  assign O_ram_we    = ram_we_q;
  assign O_ram_addr  = ram_addr_q;
  assign O_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_sysram_port_arb.sv
// Directed bench for sysram_port_arb with a 2-cycle-latency RAM model whose unwritten words read as 0xC0DE0000|addr.
module tb_sysram_port_arb;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_pxie_wr_vld, I_uart_wr_vld;
  logic        O_pxie_wr_rdy, O_uart_wr_rdy;
  logic [15:0] I_pxie_wr_addr, I_uart_wr_addr;
  logic [31:0] I_pxie_wr_data, I_uart_wr_data;
  logic        I_rd_start, I_rd_ready;
  logic [15:0] I_rd_addr, I_rd_len;
  logic        O_rd_busy, O_rd_vld, O_rd_last, O_rd_done;
  logic [31:0] O_rd_data;
  logic        O_ram_en, O_ram_we;
  logic [15:0] O_ram_addr;
  logic [31:0] O_ram_wdata, I_ram_rdata;

  sysram_port_arb dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_pxie_wr_vld(I_pxie_wr_vld), .O_pxie_wr_rdy(O_pxie_wr_rdy),
    .I_pxie_wr_addr(I_pxie_wr_addr), .I_pxie_wr_data(I_pxie_wr_data),
    .I_uart_wr_vld(I_uart_wr_vld), .O_uart_wr_rdy(O_uart_wr_rdy),
    .I_uart_wr_addr(I_uart_wr_addr), .I_uart_wr_data(I_uart_wr_data),
    .I_rd_start(I_rd_start), .I_rd_addr(I_rd_addr), .I_rd_len(I_rd_len),
    .I_rd_ready(I_rd_ready), .O_rd_busy(O_rd_busy), .O_rd_vld(O_rd_vld),
    .O_rd_data(O_rd_data), .O_rd_last(O_rd_last), .O_rd_done(O_rd_done),
    .O_ram_en(O_ram_en), .O_ram_we(O_ram_we), .O_ram_addr(O_ram_addr),
    .O_ram_wdata(O_ram_wdata), .I_ram_rdata(I_ram_rdata)
  );

  always #5 I_clk = ~I_clk;

  logic [31:0] mem [0:65535];
  logic [31:0] rs1, rs2;
  logic        init_done = 1'b0;
  always @(posedge I_clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 32'hC0DE0000 | i;
      init_done <= 1'b1;
    end else if (O_ram_en && O_ram_we) begin
      mem[O_ram_addr] <= O_ram_wdata;
    end
    rs1 <= mem[O_ram_addr];
    rs2 <= rs1;
  end
  assign I_ram_rdata = rs2;

  typedef struct packed { logic we; logic [15:0] addr; logic [31:0] wdata; logic [31:0] cyc; } op_t;
  typedef struct packed { logic last; logic [31:0] data; logic [31:0] cyc; } out_t;
  op_t         op_q[$];
  out_t        out_q[$];
  logic [31:0] cyc = 32'd0;
  int          done_cnt = 0;
  logic [31:0] done_cyc = 32'd0;

  always @(posedge I_clk) cyc <= cyc + 32'd1;

  always @(negedge I_clk) begin
    if (!I_rst) begin
      if (O_ram_en) op_q.push_back('{O_ram_we, O_ram_addr, O_ram_wdata, cyc});
      if (O_rd_vld) out_q.push_back('{O_rd_last, O_rd_data, cyc});
      if (O_rd_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60 && done_cnt == 0; k++) tick();
    chk(tag, done_cnt, 1);
  endtask

  task automatic clear_logs();
    op_q.delete();
    out_q.delete();
    done_cnt = 0;
  endtask

  logic [15:0] a;
  logic        hp, hu;
  logic [15:0] exp_addr [0:7];

  initial begin
    I_rst = 1'b1;
    I_pxie_wr_vld = 1'b1; I_pxie_wr_addr = 16'h0; I_pxie_wr_data = 32'h0;
    I_uart_wr_vld = 1'b0; I_uart_wr_addr = 16'h0; I_uart_wr_data = 32'h0;
    I_rd_start = 1'b0; I_rd_addr = 16'h0; I_rd_len = 16'h0; I_rd_ready = 1'b1;
    tick(); tick();
    chk("reset_ctl", {O_ram_en, O_ram_we, O_rd_vld, O_rd_last, O_rd_done, O_rd_busy,
                      O_pxie_wr_rdy, O_uart_wr_rdy}, 0);
    chk("reset_dat", {O_ram_addr, O_ram_wdata}, 0);
    I_rst = 1'b0;
    I_pxie_wr_vld = 1'b0;
    tick();

    // Uncontended PCIe write
    tick();
    I_pxie_wr_vld = 1'b1; I_pxie_wr_addr = 16'h0010; I_pxie_wr_data = 32'hDEADBEEF;
    #1;
    chk("pxie_rdy_same_cycle", O_pxie_wr_rdy, 1);
    chk("uart_rdy_no_vld", O_uart_wr_rdy, 0);
    tick();
    I_pxie_wr_vld = 1'b0;
    chk("pxie_ram_strobe", {O_ram_en, O_ram_we, O_ram_addr, O_ram_wdata}, {2'b11, 16'h0010, 32'hDEADBEEF});
    tick();
    chk("pxie_strobe_one_cycle", O_ram_en, 0);

    // UART write then read of same address in the next grant slot
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0020; I_rd_len = 16'd1;
    I_uart_wr_vld = 1'b1; I_uart_wr_addr = 16'h0020; I_uart_wr_data = 32'h12345678;
    #1;
    chk("uart_rdy", O_uart_wr_rdy, 1);
    tick();
    I_rd_start = 1'b0; I_uart_wr_vld = 1'b0;
    wait_done("raw_done");
    chk("raw_ops", op_q.size(), 2);
    if (op_q.size() == 2)
      chk("raw_order", {op_q[0].we, op_q[1].we, op_q[1].addr, op_q[1].cyc - op_q[0].cyc},
          {2'b10, 16'h0020, 32'd1});
    chk("raw_words", out_q.size(), 1);
    if (out_q.size() == 1) chk("raw_data", {out_q[0].last, out_q[0].data}, {1'b1, 32'h12345678});

    // Burst across the address wrap
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'hFFFE; I_rd_len = 16'd4;
    tick();
    I_rd_start = 1'b0;
    chk("wrap_busy", O_rd_busy, 1);
    wait_done("wrap_done");
    chk("wrap_idle", O_rd_busy, 0);
    chk("wrap_ops", op_q.size(), 4);
    chk("wrap_words", out_q.size(), 4);
    if (op_q.size() == 4 && out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        a = 16'hFFFE + i[15:0];
        chk("wrap_addr", {op_q[i].we, op_q[i].addr}, {1'b0, a});
        chk("wrap_data", {out_q[i].last, out_q[i].data}, {(i == 3), 32'hC0DE0000 | {16'h0, a}});
      end
      chk("wrap_latency", out_q[0].cyc - op_q[0].cyc, 3);
      chk("wrap_done_after_last", done_cyc - out_q[3].cyc, 1);
    end

    // Zero-length burst, then a start while busy
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0050; I_rd_len = 16'd0;
    tick();
    I_rd_start = 1'b0;
    chk("len0_done", {O_rd_done, O_rd_busy}, 2'b10);
    tick();
    chk("len0_done_pulse", O_rd_done, 0);
    tick(); tick(); tick();
    chk("len0_no_ram", op_q.size(), 0);
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0100; I_rd_len = 16'd5;
    tick();
    I_rd_start = 1'b0;
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0200; I_rd_len = 16'd3;
    tick();
    I_rd_start = 1'b0;
    wait_done("busy_start_done");
    for (int k = 0; k < 10; k++) tick();
    chk("busy_start_words", out_q.size(), 5);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_ops", op_q.size(), 5);
    if (out_q.size() == 5) begin
      chk("busy_start_first", {out_q[0].last, out_q[0].data}, {1'b0, 32'hC0DE0100});
      chk("busy_start_last", {out_q[4].last, out_q[4].data}, {1'b1, 32'hC0DE0104});
    end

    // Downstream pause after three beats
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0300; I_rd_len = 16'd8;
    tick();
    I_rd_start = 1'b0;
    tick(); tick(); tick();
    I_rd_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("pause_ops", op_q.size(), 3);
    chk("pause_words", out_q.size(), 3);
    I_rd_ready = 1'b1;
    wait_done("pause_done");
    chk("pause_total", out_q.size(), 8);
    if (out_q.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("pause_data", {out_q[i].last, out_q[i].data}, {(i == 7), 32'hC0DE0300 + i});

    // Three-way contention
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0400; I_rd_len = 16'd6;
    tick();
    I_rd_start = 1'b0;
    I_pxie_wr_vld = 1'b1; I_pxie_wr_addr = 16'h0500; I_pxie_wr_data = 32'h11111111;
    I_uart_wr_vld = 1'b1; I_uart_wr_addr = 16'h0501; I_uart_wr_data = 32'h22222222;
    for (int k = 0; k < 20 && (I_pxie_wr_vld || I_uart_wr_vld); k++) begin
      #1;
      hp = O_pxie_wr_rdy;
      hu = O_uart_wr_rdy;
      tick();
      if (hp) I_pxie_wr_vld = 1'b0;
      if (hu) I_uart_wr_vld = 1'b0;
    end
    chk("arb_writes_taken", {I_pxie_wr_vld, I_uart_wr_vld}, 2'b00);
    wait_done("arb_done");
`ifdef SYSRAM_ARB_RR_EN
    exp_addr[0] = 16'h0500; exp_addr[1] = 16'h0501;
    for (int i = 0; i < 6; i++) exp_addr[i+2] = 16'h0400 + i[15:0];
`else
    for (int i = 0; i < 6; i++) exp_addr[i] = 16'h0400 + i[15:0];
    exp_addr[6] = 16'h0500; exp_addr[7] = 16'h0501;
`endif
    chk("arb_ops", op_q.size(), 8);
    if (op_q.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("arb_grant_order", {op_q[i].we, op_q[i].addr}, {exp_addr[i][15:8] == 8'h05, exp_addr[i]});
    chk("arb_words", out_q.size(), 6);
    if (out_q.size() == 6) chk("arb_last", {out_q[5].last, out_q[5].data}, {1'b1, 32'hC0DE0405});

    // Reset in the middle of a burst
    clear_logs();
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0600; I_rd_len = 16'd6;
    tick();
    I_rd_start = 1'b0;
    tick(); tick();
    I_rst = 1'b1;
    #1;
    chk("midrst_ctl", {O_ram_en, O_ram_we, O_rd_vld, O_rd_last, O_rd_done, O_rd_busy,
                       O_pxie_wr_rdy, O_uart_wr_rdy}, 0);
    chk("midrst_dat", {O_ram_addr, O_rd_data}, 0);
    tick(); tick();
    I_rst = 1'b0;
    clear_logs();
    for (int k = 0; k < 15; k++) tick();
    chk("midrst_no_words", out_q.size(), 0);
    chk("midrst_no_done", done_cnt, 0);
    tick();
    I_rd_start = 1'b1; I_rd_addr = 16'h0010; I_rd_len = 16'd1;
    tick();
    I_rd_start = 1'b0;
    wait_done("post_rst_done");
    chk("post_rst_words", out_q.size(), 1);
    if (out_q.size() == 1) chk("post_rst_data", {out_q[0].last, out_q[0].data}, {1'b1, 32'hDEADBEEF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysram_port_arb.md
SYSRAM_PORT_ARB -- requirements
Module: sysram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: RAM word-address width.
REQ-002 SHALL have parameter RAM_LAT, default 2: fixed RAM read latency in cycles, legal range 1..4.
REQ-003 I_clk  in  1  single clock; all logic is synchronous to I_clk.
REQ-004 I_rst  in  1  reset, asynchronous and active-high.
REQ-005 I_pxie_wr_vld / O_pxie_wr_rdy / I_pxie_wr_addr / I_pxie_wr_data  in/out/in/in  1/1/ADDR_W/32  PCIe host write requester, valid/ready.
REQ-006 I_uart_wr_vld / O_uart_wr_rdy / I_uart_wr_addr / I_uart_wr_data  in/out/in/in  1/1/ADDR_W/32  UART write requester, valid/ready.
REQ-007 I_rd_start / I_rd_addr / I_rd_len  in  1/ADDR_W/16  C2H burst-read command: start pulse, first address, word count.
REQ-008 I_rd_ready  in  1  downstream can accept at least RAM_LAT+2 further words.
REQ-009 O_rd_busy / O_rd_vld / O_rd_data / O_rd_last / O_rd_done  out  1/1/32/1/1  burst status and readback stream.
REQ-010 O_ram_en / O_ram_we / O_ram_addr / O_ram_wdata / I_ram_rdata  out/out/out/out/in  1/1/ADDR_W/32/32  single shared RAM port.

Function
REQ-011 SHALL define three requesters: P0 = PCIe write, P1 = UART write, P2 = burst-read beat.
REQ-012 P2 SHALL request only while the burst is in RD_RUN, words remain, and I_rd_ready=1.
REQ-013 SHALL grant at most one requester per cycle.
REQ-014 A write handshake SHALL complete in cycle T when vld=1 and rdy=1.
REQ-015 O_*_wr_rdy SHALL be combinational from vld and arbiter state, and SHALL never depend on rdy.
REQ-016 A write granted in cycle T SHALL drive O_ram_en=1, O_ram_we=1 and the captured addr/data in cycle T+1 only.
REQ-017 A read beat granted in cycle T SHALL drive O_ram_en=1, O_ram_we=0 and the beat address in T+1.
REQ-018 For a read beat granted in T, I_ram_rdata SHALL be sampled at T+1+RAM_LAT.
REQ-019 For a read beat granted in T, O_rd_vld=1 with registered O_rd_data SHALL appear at T+2+RAM_LAT.
REQ-020 O_rd_vld SHALL NOT be back-pressured.
REQ-021 Burst state machine: RD_IDLE -> (I_rd_start, len>0) RD_RUN -> (last beat granted) RD_DRAIN -> (last O_rd_vld) RD_IDLE.
REQ-022 I_rd_start with I_rd_len=0 SHALL remain in RD_IDLE, issue no reads, and pulse O_rd_done in the next cycle.
REQ-023 O_rd_busy SHALL be 1 in RD_RUN and RD_DRAIN; I_rd_start while busy SHALL be ignored.
REQ-024 The beat address SHALL increment by 1 per granted beat and wrap modulo 2^ADDR_W (0xFFFF -> 0x0000).
REQ-025 O_rd_last SHALL accompany the final O_rd_vld of a burst.
REQ-026 O_rd_done SHALL pulse for one cycle in the cycle after that final O_rd_vld.
REQ-027 Read data SHALL be returned in issue order.
REQ-028 Interleaved writes SHALL never drop or duplicate a read beat.
REQ-029 A write and a read to the same address granted in successive cycles SHALL take effect in grant order, and the read SHALL return the newly written data.

Reset
REQ-030 On I_rst=1, all outputs SHALL be 0 and the burst state machine SHALL be RD_IDLE.
REQ-031 On I_rst=1, in-flight read beats SHALL be discarded, the arbiter pointer SHALL be set to P0, and no O_rd_done SHALL be produced for an aborted burst.
REQ-032 Outputs SHALL be updated from the first I_clk edge after I_rst deasserts.

Configuration
REQ-033 Macro SYSRAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-034 With SYSRAM_ARB_RR_EN defined, arbitration SHALL be round-robin in order P0 -> P1 -> P2, with the pointer moving to the requester after the one granted.
REQ-035 With SYSRAM_ARB_RR_EN defined, any continuously requesting port SHALL be granted within 3 cycles.
REQ-036 Without SYSRAM_ARB_RR_EN, arbitration SHALL be fixed priority P2 > P0 > P1, with no pointer state.

Verification
REQ-037 PCIe write addr 0x0010, data 0xDEADBEEF, no contention -> O_pxie_wr_rdy=1 same cycle; next cycle O_ram_en=1, O_ram_we=1, addr 0x0010, data 0xDEADBEEF.
REQ-038 Burst addr 0xFFFE, len 4, I_rd_ready=1 -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001; 4 O_rd_vld in order; O_rd_last on the 4th; O_rd_done one cycle later.
REQ-039 P0, P1 and a burst of len 6 all requesting continuously with SYSRAM_ARB_RR_EN -> grant sequence P0, P1, P2 repeating; without the macro -> 6 P2 grants, then P0, then P1.
REQ-040 Burst len 8, I_rd_ready deasserted after beat 3 for 10 cycles -> exactly 3 words out; pause; then 5 more words; total 8 with correct data.
REQ-041 I_rd_start with len 0 -> no O_ram_en; O_rd_done pulses next cycle. Second I_rd_start during an active len-5 burst -> ignored; exactly 5 words returned.
REQ-042 I_rst asserted after 2 of 6 beats issued -> all outputs 0 immediately; no O_rd_vld or O_rd_done afterwards; a new len-1 burst after reset completes normally.
